present_req_arbiter: RTL and testbench

//  Shares one PRESENT_ENCRYPT core between NUM_REQ requesters. Requesters use valid/ready handshakes.
//  - Round-robin arbitration picks one requester at a time.
//  - The winner's block and key are captured, the core is sequenced through a single load pulse, and
//    the block waits for the core's done flag.
//  - The ciphertext is returned to the requester that owns the transaction.

---
 rtl/present_req_arbiter.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_present_req_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_req_arbiter.sv
// -----------------------------------------------------------------------------
// present_req_arbiter
//
// Shares one PRESENT_ENCRYPT core between NUM_REQ requesters. A round-robin
// arbiter accepts one request at a time with a valid/ready handshake and
// captures its plaintext and key. It then pulses the core's load input once
// and waits for the core's done flag. The ciphertext goes back to the
// requester that owns the transaction. Only one transaction is in flight.
//
// FSM: IDLE -> LOAD -> WAIT -> RESP -> IDLE
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   TIMEOUT_CYC  WAIT watchdog limit in cycles (only with PRESENT_TIMEOUT_EN)
//
// Optional feature macro
//   PRESENT_TIMEOUT_EN  adds the WAIT-state watchdog. When it fires, the
//                       response carries rsp_err=1 and rsp_data=0. When the
//                       macro is undefined, WAIT waits forever and rsp_err
//                       is 0.
//
// Ports
//   clk            clock, all logic on posedge
//   rst_n          synchronous reset, active low
//   req_valid      per-requester request valid
//   req_ready      per-requester accept (one-hot or zero)
//   req_data       plaintext, requester i uses [64*i +: 64]
//   req_key        key, requester i uses [128*i +: 128]
//   rsp_valid      per-requester response valid (one-hot or zero)
//   rsp_ready      per-requester response accept
//   rsp_data       ciphertext for the requester flagged in rsp_valid
//   rsp_err        response is a watchdog abort
//   busy           high in every state except IDLE
//   core_load      single-cycle load pulse to the cipher core
//   core_in_data   plaintext to the core (held from capture)
//   core_key       key to the core (held from capture)
//   core_out_data  ciphertext from the core
//   core_done      done flag from the core (sticky until the next load)
// -----------------------------------------------------------------------------
module present_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [64*NUM_REQ-1:0]    req_data,
    input  logic [128*NUM_REQ-1:0]   req_key,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [63:0]              rsp_data,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     core_load,
    output logic [63:0]              core_in_data,
    output logic [127:0]             core_key,
    input  logic [63:0]              core_out_data,
    input  logic                     core_done
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Reject configurations outside the supported range at elaboration.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("present_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    state_t              state;
    state_t              state_d;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    owner;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    cand;
    logic                grant_found;
    logic                accept;
    logic                rsp_fire;
    logic                timeout_hit;
    logic [63:0]         sel_data;
    logic [127:0]        sel_key;
    logic [63:0]         data_q;
    logic [127:0]        key_q;
    logic [63:0]         rsp_data_q;
    logic [PTR_W-1:0]    next_ptr;

    // -------------------------------------------------------------------------
    // Round-robin grant: the first valid requester at or after rr_ptr.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default before any branch.
        // Without that, a path that skips the assignment would infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Mux the winner's data and key. Constant loop indices keep every
    // part-select static.
    always_comb begin
        sel_data = '0;
        sel_key  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_data = req_data[64*i +: 64];
                sel_key  = req_key[128*i +: 128];
            end
        end
    end

    // req_ready is combinational from IDLE. It is also gated by rst_n, so no
    // requester is told it was accepted while the block is held in reset.
    assign accept = rst_n && (state == S_IDLE) && grant_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == S_RESP) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    // Only the owner's rsp_ready completes the response.
    assign rsp_fire = (state == S_RESP) && rsp_ready[owner];

    // The next pointer wraps with an explicit modulo.
    assign next_ptr = PTR_W'((int'(owner) + 1) % NUM_REQ);

    // -------------------------------------------------------------------------
    // FSM: state register and next-state / output decode.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // registers then update together from the values seen before the edge.
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        core_load = 1'b0;
        unique case (state)
            S_IDLE: begin
                // core_done is ignored here; it is sticky from the previous job.
                if (accept) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                core_load = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // The core clears done on the load edge, so a done seen here
                // always belongs to the current job.
                if (core_done || timeout_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // -------------------------------------------------------------------------
    // Datapath: capture registers, owner, round-robin pointer, response data.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            owner      <= '0;
            data_q     <= '0;
            key_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                owner  <= grant_idx;
                data_q <= sel_data;
                key_q  <= sel_key;
            end
            if (state == S_WAIT) begin
                // When done and the watchdog fire together, done wins.
                if (core_done) begin
                    rsp_data_q <= core_out_data;
                end else if (timeout_hit) begin
                    rsp_data_q <= '0;
                end
            end
            if (rsp_fire) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    assign core_in_data = data_q;
    assign core_key     = key_q;
    assign rsp_data     = rsp_data_q;

    // -------------------------------------------------------------------------
    // Optional WAIT watchdog.
    // -------------------------------------------------------------------------
`ifdef PRESENT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             rsp_err_q;

    // wait_cnt is 0 in the first WAIT cycle. The watchdog therefore fires in
    // the TIMEOUT_CYC-th WAIT cycle that has no done.
    assign timeout_hit = (state == S_WAIT) && !core_done &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (state == S_LOAD) begin
                wait_cnt <= '0;
            end else if ((state == S_WAIT) && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (state == S_WAIT) begin
                if (core_done) begin
                    rsp_err_q <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_err_q <= 1'b1;
                end
            end else if (rsp_fire) begin
                rsp_err_q <= 1'b0;
            end
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Protocol invariants.
    // -------------------------------------------------------------------------
    a_req_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));
    a_rsp_valid_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(rsp_valid));
    a_load_single      : assert property (@(posedge clk) disable iff (!rst_n)
        core_load |=> !core_load);

endmodule

// File: tb/tb_present_req_arbiter.sv
module tb_present_req_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam int LAT_NORMAL  = 7;   // load cycle -> first rsp_valid cycle
`ifdef PRESENT_TIMEOUT_EN
    localparam int LAT_TIMEOUT = TIMEOUT_CYC + 1;
`else
    localparam int LAT_TIMEOUT = 0;   // 0 means no response is expected
`endif

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [64*NUM_REQ-1:0]    req_data;
    logic [128*NUM_REQ-1:0]   req_key;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [63:0]              rsp_data;
    logic                     rsp_err;
    logic                     busy;
    logic                     core_load;
    logic [63:0]              core_in_data;
    logic [127:0]             core_key;
    logic [63:0]              core_out_data;
    logic                     core_done;

    int total = 0;
    int bad   = 0;

    present_req_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_key       (req_key),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .core_load     (core_load),
        .core_in_data  (core_in_data),
        .core_key      (core_key),
        .core_out_data (core_out_data),
        .core_done     (core_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stub core: done goes high 6 cycles after the load cycle, and out_data
    // is ~in_data. stub_stuck keeps done low.
    logic stub_stuck;
    logic stub_done;
    logic [63:0] stub_out;
    int stub_cnt;

    initial begin
        stub_done = 1'b0;
        stub_out  = '0;
        stub_cnt  = 0;
    end

    always @(posedge clk) begin
        if (core_load) begin
            stub_done <= 1'b0;
            stub_out  <= ~core_in_data;
            stub_cnt  <= 5;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1 && !stub_stuck) stub_done <= 1'b1;
        end
    end

    assign core_done     = stub_done;
    assign core_out_data = stub_out;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Requester g gets exactly d/k. The other requesters get distinct values,
    // so selecting the wrong requester shows up in the captured data.
    task automatic drive_reqs(input logic [3:0] valid, input logic [63:0] d,
                              input logic [127:0] k, input int g);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[64*i +: 64]   = d ^ {8'(i ^ g), 56'h0};
            req_key[128*i +: 128]  = k ^ {8'(i ^ g), 120'h0};
        end
        req_valid = valid;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req_ready"},    128'(req_ready),    128'h0);
        check({tag, " rsp_valid"},    128'(rsp_valid),    128'h0);
        check({tag, " rsp_data"},     128'(rsp_data),     128'h0);
        check({tag, " rsp_err"},      128'(rsp_err),      128'h0);
        check({tag, " busy"},         128'(busy),         128'h0);
        check({tag, " core_load"},    128'(core_load),    128'h0);
        check({tag, " core_in_data"}, 128'(core_in_data), 128'h0);
        check({tag, " core_key"},     core_key,           128'h0);
    endtask

    // One full transaction, starting and ending just after a negedge.
    // If exp_lat is 0, no response is expected.
    task automatic do_txn(input string tag, input logic [3:0] valid, input logic [3:0] exp_g,
                          input logic [63:0] d, input logic [127:0] k,
                          input int hold, input int exp_lat, input logic exp_err);
        int g;
        int n;
        int limit;
        logic [63:0] exp_rsp;
        g = 0;
        for (int i = 0; i < NUM_REQ; i++) if (exp_g[i]) g = i;
        exp_rsp = exp_err ? 64'h0 : ~d;

        drive_reqs(valid, d, k, g);
        #1;
        n = 0;
        while (req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        check({tag, " grant"}, 128'(req_ready), 128'(exp_g));
        if (req_ready == '0) return;

        tick();  // LOAD cycle
        check({tag, " core_load"},    128'(core_load),    128'h1);
        check({tag, " core_in_data"}, 128'(core_in_data), 128'(d));
        check({tag, " core_key"},     core_key,           k);
        check({tag, " busy in load"}, 128'(busy),         128'h1);

        limit = (exp_lat == 0) ? 100 : exp_lat + 10;
        n = 0;
        do begin
            tick();
            n++;
            if (busy !== 1'b1) check({tag, " busy in wait"}, 128'(busy), 128'h1);
        end while (rsp_valid == '0 && n < limit);

        if (exp_lat == 0) begin
            check({tag, " no response"}, 128'(rsp_valid), 128'h0);
            check({tag, " still busy"},  128'(busy),      128'h1);
            return;
        end

        check({tag, " latency"},   128'(n),         128'(exp_lat));
        check({tag, " rsp_valid"}, 128'(rsp_valid), 128'(exp_g));
        check({tag, " rsp_data"},  128'(rsp_data),  128'(exp_rsp));
        check({tag, " rsp_err"},   128'(rsp_err),   128'(exp_err));
        if (rsp_valid == '0) return;

        // Other requesters' rsp_ready is asserted while the owner holds off.
        rsp_ready = ~exp_g;
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, " hold rsp_valid"}, 128'(rsp_valid), 128'(exp_g));
            check({tag, " hold rsp_data"},  128'(rsp_data),  128'(exp_rsp));
            check({tag, " hold req_ready"}, 128'(req_ready), 128'h0);
        end
        check({tag, " no accept during resp"}, 128'(req_ready), 128'h0);
        rsp_ready = exp_g;
        tick();
        check({tag, " idle busy"},      128'(busy),      128'h0);
        check({tag, " idle rsp_valid"}, 128'(rsp_valid), 128'h0);
        check({tag, " idle rsp_err"},   128'(rsp_err),   128'h0);
        rsp_ready = '0;
    endtask

    typedef struct {
        logic [3:0]   valid;
        logic [3:0]   grant;
        logic [63:0]  data;
        logic [127:0] key;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // rr_ptr is 0 after reset and advances to owner+1 after each response.
        vecs[0]  = '{4'b1111, 4'b0001, 64'h1111_0000_0000_0001, 128'h10};
        vecs[1]  = '{4'b1111, 4'b0010, 64'h2222_0000_0000_0002, 128'h20};
        vecs[2]  = '{4'b1111, 4'b0100, 64'h3333_0000_0000_0003, 128'h30};
        vecs[3]  = '{4'b1111, 4'b1000, 64'h4444_0000_0000_0004, 128'h40};
        vecs[4]  = '{4'b1111, 4'b0001, 64'h5555_0000_0000_0005, 128'h50};
        vecs[5]  = '{4'b1111, 4'b0010, 64'h6666_0000_0000_0006, 128'h60};
        vecs[6]  = '{4'b1111, 4'b0100, 64'h7777_0000_0000_0007, 128'h70};
        vecs[7]  = '{4'b1111, 4'b1000, 64'h8888_0000_0000_0008, 128'h80};
        vecs[8]  = '{4'b0100, 4'b0100, 64'h0123456789ABCDEF,    128'h1};   // ptr 0 -> 3
        vecs[9]  = '{4'b1010, 4'b1000, 64'hDEAD_BEEF_0000_0009, 128'h90};  // ptr 3 -> 0
        vecs[10] = '{4'b1010, 4'b0010, 64'hCAFE_F00D_0000_000A, 128'hA0};  // ptr 0 -> 2
        vecs[11] = '{4'b0001, 4'b0001, 64'hFFFF_FFFF_FFFF_FFFF, 128'hB0};  // ptr 2 -> 1
        vecs[12] = '{4'b1001, 4'b1000, 64'h0000_0000_0000_0000, 128'hC0};  // ptr 1 -> 0

        rst_n      = 1'b0;
        stub_stuck = 1'b0;
        rsp_ready  = '0;
        drive_reqs(4'b1111, 64'h0F0F_0F0F_0F0F_0F0F, 128'h5, 0);

        // Reset with all requests valid: every output stays 0.
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;

        // Table: round-robin order, single-requester patterns and wrap cases.
        for (int v = 0; v < 13; v++) begin
            do_txn($sformatf("vec%0d", v), vecs[v].valid, vecs[v].grant,
                   vecs[v].data, vecs[v].key, 0, LAT_NORMAL, 1'b0);
        end

        // Response back-pressure for 10 cycles (rr_ptr 0 -> grant 0).
        do_txn("hold", 4'b1111, 4'b0001, 64'hA5A5_5A5A_1234_5678, 128'hBEEF, 10, LAT_NORMAL, 1'b0);

        // Reset during WAIT (rr_ptr 1 -> grant 1).
        drive_reqs(4'b1111, 64'h1357_9BDF_0246_8ACE, 128'h77, 1);
        #1;
        check("midrst grant", 128'(req_ready), 128'b0010);
        tick();
        check("midrst load", 128'(core_load), 128'h1);
        tick();
        tick();
        check("midrst busy in wait", 128'(busy), 128'h1);
        rst_n = 1'b0;
        tick();
        check_all_zero("midrst");
        tick();
        check("midrst ready in reset", 128'(req_ready), 128'h0);
        rst_n = 1'b1;
        do_txn("after rst", 4'b1111, 4'b0001, 64'h2468_ACE0_1357_9BDF, 128'h99, 0, LAT_NORMAL, 1'b0);

        // Core done stuck low (rr_ptr 1, only requester 2 valid).
        stub_stuck = 1'b1;
        do_txn("stuck", 4'b0100, 4'b0100, 64'h0BAD_0BAD_0BAD_0BAD, 128'h42, 0, LAT_TIMEOUT, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
